// File: rtl/rr_port_arbiter_if.sv
// Channel-side and consumer-side signal bundle of the round-robin port arbiter.
// The slave view belongs to the arbiter; the master view belongs to whoever drives it.
interface rr_port_arbiter_if #(
    parameter int PCKG_SZ = 40,
    parameter int N_PORTS = 4
);
    logic [N_PORTS-1:0][PCKG_SZ-1:0] data_in;
    logic [N_PORTS-1:0]              pndng_in;
    logic [N_PORTS-1:0]              pop_out;
    logic [PCKG_SZ-1:0]              data_out;
    logic                            pndng_out;
    logic                            pop_in;
    logic                            full;
    logic [15:0]                     drop_cnt;

    modport slave (
        input  data_in, pndng_in, pop_in,
        output pop_out, data_out, pndng_out, full, drop_cnt
    );

    modport master (
        output data_in, pndng_in, pop_in,
        input  pop_out, data_out, pndng_out, full, drop_cnt
    );
endinterface

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter: pops one packet per grant from N_PORTS channels, keeps those
// addressed to ID in a first-word-fall-through FIFO and counts the rest as drops.
module rr_port_arbiter #(
    parameter int PCKG_SZ    = 40,
    parameter int N_PORTS    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ID         = 0
) (
    input  logic           clk,
    input  logic           rst,
    rr_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0]         ID_L        = 8'(ID);
    localparam logic [PW:0]        NP_L        = (PW + 1)'(N_PORTS);
    localparam logic [PW-1:0]      LAST_PORT_L = PW'(N_PORTS - 1);
    localparam logic [AW-1:0]      LAST_SLOT_L = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]      DEPTH_L     = CW'(FIFO_DEPTH);
    localparam logic [N_PORTS-1:0] ONE_L       = N_PORTS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_r, next_state_s;
    logic [PW-1:0]        gnt_r, gnt_next_s;
    logic [PW-1:0]        rr_ptr_r, rr_next_s;
    logic [PW-1:0]        sel_s;
    logic                 found_s;
    logic [N_PORTS-1:0]   pop_out_r, pop_next_s;
    logic [PCKG_SZ-1:0]   hold_r;
    logic                 hold_load_s;
    logic                 id_match_s;
    logic                 push_s;
    logic                 drop_s;
    logic [15:0]          drop_cnt_r;

    logic [PCKG_SZ-1:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r, wr_next_s;
    logic [AW-1:0]        rd_ptr_r, rd_next_s;
    logic [CW-1:0]        count_r, count_next_s;
    logic                 pop_s;
    logic [PCKG_SZ-1:0]   data_out_r, head_next_s;
    logic                 pndng_out_r;
    logic                 full_r;

    function automatic logic [AW-1:0] slot_inc(input logic [AW-1:0] p);
        if (p == LAST_SLOT_L) begin
            return '0;
        end else begin
            return p + 1'b1;
        end
    endfunction

    assign id_match_s = (hold_r[PCKG_SZ-1 -: 8] == ID_L);

    // Cyclic search for the first pending channel starting at rr_ptr.
    always_comb begin
        logic [PW:0] idx_v;
        idx_v   = '0;
        sel_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx_v = {1'b0, rr_ptr_r} + (PW + 1)'(i);
            if (idx_v >= NP_L) begin
                idx_v = idx_v - NP_L;
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && bus.pndng_in[idx_v[PW-1:0]]) begin
                found_s = 1'b1;
                sel_s   = idx_v[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM next state; pop_out is computed one cycle early so it is registered during GRANT.
    always_comb begin
        next_state_s = state_r;
        gnt_next_s   = gnt_r;
        rr_next_s    = rr_ptr_r;
        pop_next_s   = '0;
        hold_load_s  = 1'b0;
        push_s       = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    next_state_s = GRANT;
                    gnt_next_s   = sel_s;
                    pop_next_s   = ONE_L << sel_s;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT: begin
                next_state_s = WRITE;
                hold_load_s  = 1'b1;
                if (gnt_r == LAST_PORT_L) begin
                    rr_next_s = '0;
                end else begin
                    rr_next_s = gnt_r + 1'b1;
                end
            end
            WRITE: begin
                if (!id_match_s) begin
                    drop_s       = 1'b1;
                    next_state_s = IDLE;
                end else if (!full_r || bus.pop_in) begin
                    // A consumer pop in the same cycle frees the slot this push needs.
                    push_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WRITE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM, grant, round-robin pointer and holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            rr_ptr_r  <= '0;
            pop_out_r <= '0;
            hold_r    <= '0;
        end else begin
            state_r   <= next_state_s;
            gnt_r     <= gnt_next_s;
            rr_ptr_r  <= rr_next_s;
            pop_out_r <= pop_next_s;
            if (hold_load_s) begin
                hold_r <= bus.data_in[gnt_r];
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Saturating count of packets discarded for a foreign destination ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    // FIFO pointer/count update and the head value visible after the edge.
    always_comb begin
        pop_s        = 1'b0;
        wr_next_s    = wr_ptr_r;
        rd_next_s    = rd_ptr_r;
        count_next_s = count_r;
        head_next_s  = data_out_r;
        if (bus.pop_in && (count_r != '0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push_s) begin
            wr_next_s = slot_inc(wr_ptr_r);
        end else begin
            wr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_next_s = slot_inc(rd_ptr_r);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 1'b1;
            2'b01:   count_next_s = count_r - 1'b1;
            default: count_next_s = count_r;
        endcase
        // The slot being written becomes the head when the FIFO is otherwise drained.
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = hold_r;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage, left unreset since only slots between the pointers are ever read out.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= hold_r;
        end
    end

    // FIFO pointers and registered status/head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            data_out_r  <= '0;
            pndng_out_r <= 1'b0;
            full_r      <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_next_s;
            rd_ptr_r    <= rd_next_s;
            count_r     <= count_next_s;
            data_out_r  <= head_next_s;
            pndng_out_r <= (count_next_s != '0);
            full_r      <= (count_next_s == DEPTH_L);
        end
    end

    assign bus.pop_out   = pop_out_r;
    assign bus.data_out  = data_out_r;
    assign bus.pndng_out = pndng_out_r;
    assign bus.full      = full_r;
    assign bus.drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed bench for rr_port_arbiter (4 ports, FIFO depth 2, ID 0x05); each task
// drives one scenario and compares outputs against hand-computed values.
module tb_rr_port_arbiter;
    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;

    rr_port_arbiter_if #(.PCKG_SZ(40), .N_PORTS(4)) bus ();

    rr_port_arbiter #(
        .PCKG_SZ(40), .N_PORTS(4), .FIFO_DEPTH(2), .ID(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.pndng_in = 4'b0000;
        bus.pop_in   = 1'b0;
        bus.data_in  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pndng_in = 4'b1111;
        bus.pop_in   = 1'b0;
        bus.data_in  = '0;
        tick();
        tick();
        chk_cnt++;
        if (bus.pop_out !== 4'b0000) $display("FAIL reset_pop_out: got %b expected 0000", bus.pop_out);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.pndng_out, bus.full} !== 2'b00) $display("FAIL reset_flags: got pndng_out/full=%b expected 00", {bus.pndng_out, bus.full});
        else pass_cnt++;
        chk_cnt++;
        if (bus.data_out !== 40'h0 || bus.drop_cnt !== 16'h0) $display("FAIL reset_data: got data_out=%h drop_cnt=%h expected 0/0", bus.data_out, bus.drop_cnt);
        else pass_cnt++;
        rst = 1'b0;
        bus.pndng_in = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        bus.data_in[2] = 40'h05_00000001;
        bus.pndng_in   = 4'b0100;
        tick();
        chk_cnt++;
        if (bus.pop_out !== 4'b0100) $display("FAIL single_pop: got %b expected 0100", bus.pop_out);
        else pass_cnt++;
        bus.pndng_in = 4'b0000;   // dropped during the GRANT cycle
        tick();
        chk_cnt++;
        if (bus.pop_out !== 4'b0000 || bus.pndng_out !== 1'b0) $display("FAIL single_edge2: got pop_out=%b pndng_out=%b expected 0000/0", bus.pop_out, bus.pndng_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.pndng_out !== 1'b1 || bus.data_out !== 40'h05_00000001) $display("FAIL single_push: got pndng_out=%b data_out=%h expected 1/0500000001", bus.pndng_out, bus.data_out);
        else pass_cnt++;
        bus.pop_in = 1'b1;
        tick();
        bus.pop_in = 1'b0;
        chk_cnt++;
        if (bus.pndng_out !== 1'b0) $display("FAIL single_consume: got pndng_out=%b expected 0", bus.pndng_out);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int gnt_cyc[$];
        int gnt_ch[$];
        logic [39:0] seen[$];
        logic [39:0] exp_pkt;
        do_reset();
        for (int c = 0; c < 4; c++) bus.data_in[c] = {8'h05, 32'(c)};
        bus.pndng_in = 4'b1111;
        bus.pop_in   = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                if (bus.pop_out[c]) begin
                    gnt_cyc.push_back(cyc);
                    gnt_ch.push_back(c);
                end
            end
            if (bus.pndng_out) seen.push_back(bus.data_out);
        end
        bus.pndng_in = 4'b0000;
        bus.pop_in   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_cnt++;
            if (k >= gnt_ch.size()) $display("FAIL rr_grant%0d: got no grant expected ch%0d at cycle %0d", k, k % 4, 1 + 3 * k);
            else if (gnt_ch[k] !== k % 4 || gnt_cyc[k] !== 1 + 3 * k) $display("FAIL rr_grant%0d: got ch%0d at cycle %0d expected ch%0d at cycle %0d", k, gnt_ch[k], gnt_cyc[k], k % 4, 1 + 3 * k);
            else pass_cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            exp_pkt = {8'h05, 32'(k)};
            chk_cnt++;
            if (k >= seen.size()) $display("FAIL rr_data%0d: got nothing expected %h", k, exp_pkt);
            else if (seen[k] !== exp_pkt) $display("FAIL rr_data%0d: got %h expected %h", k, seen[k], exp_pkt);
            else pass_cnt++;
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus.data_in[1] = 40'h07_00000099;
        bus.pndng_in   = 4'b0010;
        tick();
        chk_cnt++;
        if (bus.pop_out !== 4'b0010) $display("FAIL drop_pop: got %b expected 0010", bus.pop_out);
        else pass_cnt++;
        bus.pndng_in = 4'b0000;
        tick();
        chk_cnt++;
        if (bus.drop_cnt !== 16'd0) $display("FAIL drop_early: got %0d expected 0", bus.drop_cnt);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.drop_cnt !== 16'd1 || bus.pndng_out !== 1'b0) $display("FAIL drop_count: got drop_cnt=%0d pndng_out=%b expected 1/0", bus.drop_cnt, bus.pndng_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.pndng_out !== 1'b0) $display("FAIL drop_no_push: got pndng_out=%b expected 0", bus.pndng_out);
        else pass_cnt++;
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.data_in[0] = 40'h05_000000A0;
        bus.data_in[1] = 40'h05_000000A1;
        bus.data_in[2] = 40'h05_000000A2;
        bus.pndng_in   = 4'b0111;
        tick();                                   // e1
        chk_cnt++;
        if (bus.pop_out !== 4'b0001) $display("FAIL full_g0: got %b expected 0001", bus.pop_out);
        else pass_cnt++;
        bus.pndng_in[0] = 1'b0;
        tick(); tick(); tick();                   // e4
        bus.pndng_in[1] = 1'b0;
        tick(); tick();                           // e6
        chk_cnt++;
        if (bus.full !== 1'b1 || bus.data_out !== 40'h05_000000A0) $display("FAIL full_after2: got full=%b data_out=%h expected 1/05000000a0", bus.full, bus.data_out);
        else pass_cnt++;
        tick();                                   // e7
        chk_cnt++;
        if (bus.pop_out !== 4'b0100) $display("FAIL full_g2: got %b expected 0100", bus.pop_out);
        else pass_cnt++;
        bus.pndng_in[2] = 1'b0;
        tick(); tick();                           // e9: WRITE stalls
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++;
            if (bus.pop_out !== 4'b0000 || bus.full !== 1'b1) $display("FAIL full_stall%0d: got pop_out=%b full=%b expected 0000/1", k, bus.pop_out, bus.full);
            else pass_cnt++;
        end
        bus.pop_in = 1'b1;
        tick();
        chk_cnt++;
        if (bus.full !== 1'b1 || bus.data_out !== 40'h05_000000A1) $display("FAIL full_pop_push: got full=%b data_out=%h expected 1/05000000a1", bus.full, bus.data_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.full !== 1'b0 || bus.data_out !== 40'h05_000000A2) $display("FAIL full_third: got full=%b data_out=%h expected 0/05000000a2", bus.full, bus.data_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.pndng_out !== 1'b0) $display("FAIL full_drain: got pndng_out=%b expected 0", bus.pndng_out);
        else pass_cnt++;
        bus.pop_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.data_in[0] = 40'h05_000000B0;
        bus.data_in[1] = 40'h07_000000B1;
        bus.data_in[2] = 40'h05_000000B2;
        bus.pndng_in   = 4'b0111;
        tick(); tick(); tick(); tick();           // e4: ch1 granted
        bus.pndng_in[1] = 1'b0;
        tick(); tick(); tick();                   // e7: ch2 granted
        bus.pndng_in[2] = 1'b0;
        tick(); tick(); tick();                   // e10: ch0 granted again
        chk_cnt++;
        if (bus.pop_out !== 4'b0001) $display("FAIL mid_regrant: got %b expected 0001", bus.pop_out);
        else pass_cnt++;
        bus.pndng_in = 4'b0000;
        tick(); tick(); tick();                   // e13: stalled in WRITE
        chk_cnt++;
        if (bus.drop_cnt !== 16'd1 || bus.full !== 1'b1) $display("FAIL mid_before: got drop_cnt=%0d full=%b expected 1/1", bus.drop_cnt, bus.full);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({bus.pndng_out, bus.full} !== 2'b00 || bus.drop_cnt !== 16'd0 || bus.data_out !== 40'h0) $display("FAIL mid_async: got pndng_out/full=%b drop_cnt=%0d data_out=%h expected 00/0/0", {bus.pndng_out, bus.full}, bus.drop_cnt, bus.data_out);
        else pass_cnt++;
        bus.pndng_in = 4'b0011;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (bus.pop_out !== 4'b0001) $display("FAIL mid_first_grant: got %b expected 0001", bus.pop_out);
        else pass_cnt++;
        bus.pndng_in = 4'b0000;
    endtask

    task automatic test_pop_empty();
        do_reset();
        bus.pop_in = 1'b1;
        tick(); tick(); tick();
        chk_cnt++;
        if ({bus.pndng_out, bus.full} !== 2'b00) $display("FAIL empty_pop: got pndng_out/full=%b expected 00", {bus.pndng_out, bus.full});
        else pass_cnt++;
        bus.pop_in     = 1'b0;
        bus.data_in[3] = 40'h05_DEADBEEF;
        bus.pndng_in   = 4'b1000;
        tick();
        bus.pndng_in = 4'b0000;
        tick(); tick();
        chk_cnt++;
        if (bus.pndng_out !== 1'b1 || bus.data_out !== 40'h05_DEADBEEF) $display("FAIL empty_then_push: got pndng_out=%b data_out=%h expected 1/05deadbeef", bus.pndng_out, bus.data_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.pndng_out !== 1'b1 || bus.full !== 1'b0) $display("FAIL empty_count: got pndng_out=%b full=%b expected 1/0", bus.pndng_out, bus.full);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_full_stall();
        test_reset_mid();
        test_pop_empty();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
